// File: rtl/or16_arb_pkg.sv
// ----------------------------------------------------------------------------
// or16_arb_pkg
// Shared constants and helpers for the OR16 round-robin arbiter slice.
//   DATA_W  : width of the shared OR datapath
//   word_t  : one datapath word
//   clog2_f : ceil(log2(n)), used to check the requester-index width
// ----------------------------------------------------------------------------
package or16_arb_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    // ceil(log2(n)) for n >= 2; returns 1 for n <= 2 so a 2-requester build
    // still gets a 1-bit index.
    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/MyOr16.sv
// ----------------------------------------------------------------------------
// MyOr16
// Existing 16-bit bitwise-OR resource shared by the arbiter.
//   a, b : operands
//   y    : a | b
// ----------------------------------------------------------------------------
module MyOr16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    assign y = a | b;

endmodule

// File: rtl/or16_rr_picker.sv
// ----------------------------------------------------------------------------
// or16_rr_picker
// Combinational rotate-priority encoder: picks the first asserted request
// scanning ptr, ptr+1, ... modulo NREQ.
//   req_valid : per-requester valid
//   ptr       : requester with highest priority this cycle
//   gnt_valid : at least one request is valid
//   gnt_idx   : chosen requester (0 when gnt_valid is low)
// ----------------------------------------------------------------------------
module or16_rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_idx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    always_comb begin
        // Rotate so bit 0 of rot is requester ptr; the lowest set bit of rot
        // is then the offset of the winner from ptr.
        dbl       = {req_valid, req_valid} >> ptr;
        rot       = dbl[NREQ-1:0];
        gnt_valid = 1'b0;
        off       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_valid = 1'b1;
                off       = IDW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        gnt_idx = gnt_valid ? sum[IDW-1:0] : '0;
    end

endmodule

// File: rtl/or16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// or16_rr_arbiter
// Round-robin arbiter sharing one MyOr16 datapath among NREQ requesters, with
// a single registered response slot that drains and refills in one cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [16*i+15:16*i]
//   rsp_valid/rsp_ready : response slot handshake
//   rsp_data, rsp_id    : A|B of the granted request and its requester index
// Optional (macro OR16_ARB_STATS_EN):
//   grant_cnt           : transfers since reset, wraps at 16 bits
//   stall_cnt           : cycles with rsp_valid && !rsp_ready, wraps at 16 bits
// ----------------------------------------------------------------------------
module or16_rr_arbiter
    import or16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id
`ifdef OR16_ARB_STATS_EN
    ,
    output logic [15:0]            grant_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    generate
        if (IDW != clog2_f(NREQ)) begin : g_bad_idw
            $error("or16_rr_arbiter: IDW must equal ceil(log2(NREQ))");
        end
    endgenerate

    logic            rsp_valid_reg;
    word_t           rsp_data_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [IDW-1:0]  ptr_reg;

    logic            gnt_valid;
    logic [IDW-1:0]  gnt_idx;
    logic            accept_en;
    logic            xfer;
    word_t           op_a;
    word_t           op_b;
    word_t           or_y;

    word_t           a_arr [NREQ];
    word_t           b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi] = req_b[DATA_W*gi +: DATA_W];
        end
    endgenerate

    or16_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_reg),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign op_a = a_arr[gnt_idx];
    assign op_b = b_arr[gnt_idx];

    MyOr16 u_or (
        .a (op_a),
        .b (op_b),
        .y (or_y)
    );

    // Slot can take a new result when empty or being drained this cycle.
    assign accept_en = !rsp_valid_reg || rsp_ready;
    assign xfer      = gnt_valid && accept_en && rst_n;
    assign req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= or_y;
            rsp_id_reg    <= gnt_idx;
            ptr_reg       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;

`ifdef OR16_ARB_STATS_EN
    logic [15:0] grant_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (xfer) begin
                grant_cnt_reg <= grant_cnt_reg + 16'd1;
            end
            if (rsp_valid_reg && !rsp_ready) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign grant_cnt = grant_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_or16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_or16_rr_arbiter
// Self-checking bench for or16_rr_arbiter (NREQ=4). Directed scenarios plus a
// randomized run, all compared with a transaction-level reference model.
// Build with OR16_ARB_STATS_EN defined to also exercise the counters.
// ----------------------------------------------------------------------------
module tb_or16_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
`ifdef OR16_ARB_STATS_EN
    logic [15:0]       grant_cnt;
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_id;
    int          m_grants;
    int          m_stalls;
    bit          verbose;

    or16_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef OR16_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner = valid requester at the smallest circular distance from ptr.
    function automatic int exp_grant();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                d = (i - m_ptr + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g >= 0 && (!m_valid || rsp_ready)) return NREQ'(1) << g;
        return '0;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_valid  = 0;
        m_data   = 16'h0000;
        m_id     = 0;
        m_grants = 0;
        m_stalls = 0;
    endtask

    // Advance one clock edge and update the model; called with inputs stable.
    task automatic advance();
        int g;
        bit acc;
        bit stall;
        logic [15:0] av;
        logic [15:0] bv;
        g     = exp_grant();
        acc   = !m_valid || rsp_ready;
        stall = m_valid && !rsp_ready;
        if (g >= 0) begin
            av = req_a[16*g +: 16];
            bv = req_b[16*g +: 16];
        end else begin
            av = '0;
            bv = '0;
        end
        @(posedge clk);
        if (g >= 0 && acc) begin
            m_data  = av | bv;
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % NREQ;
            m_grants++;
            if (verbose) $display("[%0t] xfer req=%0d a=%h b=%h -> %h", $time, g, av, bv, m_data);
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        if (stall) m_stalls++;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_a     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs got v=%b d=%h id=%0d exp 0/0000/0", rsp_valid, rsp_data, rsp_id);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Fill the slot, then drop reset mid-cycle.
        advance();
        advance();
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL reset_prefill got=%b exp=1", rsp_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL async_reset got v=%b d=%h id=%0d exp 0/0000/0", rsp_valid, rsp_data, rsp_id);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        advance();
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 16'h1111) begin
            n_fail++; $display("FAIL reset_first_rsp got id=%0d d=%h exp 0/1111", rsp_id, rsp_data);
        end
    endtask

    task automatic test_single();
        req_valid       = 4'b0100;
        req_a           = '0;
        req_b           = '0;
        req_a[32 +: 16] = 16'h00F0;
        req_b[32 +: 16] = 16'h0F00;
        rsp_ready       = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        advance();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FF0 || rsp_id !== 2'd2) begin
            n_fail++; $display("FAIL single_rsp got v=%b d=%h id=%0d exp 1/0ff0/2", rsp_valid, rsp_data, rsp_id);
        end
        req_valid = '0;
        advance();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0FF0) begin
            n_fail++; $display("FAIL single_drain got v=%b d=%h exp 0/0ff0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'hF;
        req_a     = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
        req_b     = {16'h8000, 16'h4000, 16'h2000, 16'h1000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (req_ready !== (NREQ'(1) << (i % NREQ))) begin
                n_fail++; $display("FAIL rr_ready cycle=%0d got=%b exp=%b", i, req_ready, NREQ'(1) << (i % NREQ));
            end
            advance();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(i % NREQ)) begin
                n_fail++; $display("FAIL rr_id cycle=%0d got v=%b id=%0d exp 1/%0d", i, rsp_valid, rsp_id, i % NREQ);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid       = 4'b0010;
        req_a           = '0;
        req_b           = '0;
        req_a[16 +: 16] = 16'hA5A0;
        req_b[16 +: 16] = 16'h0005;
        rsp_ready       = 1'b1;
        advance();
        req_valid = 4'hF;
        req_a     = {16'h0F0F, 16'h1234, 16'hFFFF, 16'h00FF};
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cycle=%0d got=%b exp=0000", i, req_ready); end
            advance();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_id !== 2'd1) begin
                n_fail++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h id=%0d exp 1/a5a5/1", i, rsp_valid, rsp_data, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
        advance();
        n_checks++;
        if (rsp_id !== 2'd2 || rsp_data !== 16'h1234) begin
            n_fail++; $display("FAIL bp_release_rsp got id=%0d d=%h exp 2/1234", rsp_id, rsp_data);
        end
    endtask

    task automatic test_operands();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic [15:0] ty [3];
        ta = '{16'h0000, 16'hFFFF, 16'h5555};
        tb = '{16'h0000, 16'h0000, 16'hAAAA};
        ty = '{16'h0000, 16'hFFFF, 16'hFFFF};
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < 3; i++) begin
            req_a[15:0] = ta[i];
            req_b[15:0] = tb[i];
            advance();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ty[i] || rsp_id !== 2'd0) begin
                n_fail++; $display("FAIL operand case=%0d got v=%b d=%h id=%0d exp 1/%h/0", i, rsp_valid, rsp_data, rsp_id, ty[i]);
            end
        end
    endtask

    task automatic test_random();
        verbose = 0;
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                req_a[16*r +: 16] = 16'($urandom);
                req_b[16*r +: 16] = 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", i, req_ready, exp_ready());
            end
            advance();
            n_checks++;
            if (rsp_valid !== m_valid || rsp_data !== m_data || rsp_id !== IDW'(m_id)) begin
                n_fail++; $display("FAIL rand_rsp cycle=%0d got v=%b d=%h id=%0d exp %b/%h/%0d",
                                   i, rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id);
            end
`ifdef OR16_ARB_STATS_EN
            n_checks++;
            if (grant_cnt !== 16'(m_grants) || stall_cnt !== 16'(m_stalls)) begin
                n_fail++; $display("FAIL rand_stats cycle=%0d got g=%0d s=%0d exp %0d/%0d",
                                   i, grant_cnt, stall_cnt, m_grants & 16'hFFFF, m_stalls & 16'hFFFF);
            end
`endif
        end
        verbose = 1;
    endtask

`ifdef OR16_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        verbose   = 0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 70000; i++) advance();
        n_checks++;
        if (grant_cnt !== 16'd4464) begin n_fail++; $display("FAIL stats_grant_wrap got=%0d exp=4464", grant_cnt); end
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) advance();
        n_checks++;
        if (stall_cnt !== 16'd3 || stall_cnt !== 16'(m_stalls)) begin
            n_fail++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt);
        end
        verbose = 1;
    endtask
`endif

    initial begin
        verbose   = 1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_operands();
        test_random();
`ifdef OR16_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
